// File: rtl/dual_port_burst_reader_if.sv
// Command, ROM-port and output-stream bundle for dual_port_burst_reader.
// The abort input exists only when BURST_READER_ABORT_EN is defined.
interface dual_port_burst_reader_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              en1;
    logic              en2;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] din1;
    logic [DATA_W-1:0] din2;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
`ifdef BURST_READER_ABORT_EN
    logic              abort;
`endif

    modport master (
`ifdef BURST_READER_ABORT_EN
        input  abort,
`endif
        input  start, base_addr, len, din1, din2, out_ready,
        output busy, done, en1, en2, addr1, addr2, out_valid, out_data
    );

    modport slave (
`ifdef BURST_READER_ABORT_EN
        output abort,
`endif
        output start, base_addr, len, din1, din2, out_ready,
        input  busy, done, en1, en2, addr1, addr2, out_valid, out_data
    );
endinterface

// File: rtl/dual_port_burst_reader.sv
// Burst reader for the two-port ROM: paired reads, 4-word output FIFO, valid/ready stream.
// Optional abort input enabled by defining BURST_READER_ABORT_EN.
module dual_port_burst_reader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    dual_port_burst_reader_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    localparam logic [ADDR_W:0]   ONE = 1;
    localparam logic [ADDR_W:0]   TWO = 2;
    localparam logic [ADDR_W-1:0] A1  = 1;
    localparam logic [ADDR_W-1:0] A2  = 2;

    logic [1:0]        state, state_nx;
    logic [ADDR_W-1:0] cur, cur_src;
    logic [ADDR_W:0]   rem, rem_src;
    logic              en1, en2, cap1, cap2;
    logic [ADDR_W-1:0] addr1, addr2;
    logic [DATA_W-1:0] mem [4];
    logic [1:0]        wp, rp, push_n;
    logic [2:0]        cnt;
    logic [3:0]        occ;
    logic              pop, out_valid, abort_hit, launch, iss1, iss2;

`ifdef BURST_READER_ABORT_EN
    assign abort_hit = bus.abort && (state == ISSUE || state == DRAIN);
`else
    assign abort_hit = 1'b0;
`endif

    assign launch    = (state == IDLE) && bus.start && (bus.len != '0);
    assign cur_src   = launch ? bus.base_addr : cur;
    assign rem_src   = launch ? bus.len : rem;
    assign out_valid = (cnt != 3'd0);
    assign pop       = out_valid && bus.out_ready;
    assign push_n    = {1'b0, cap1} + {1'b0, cap2};

    // Free space counts every word not yet popped: buffered, in the ROM, or being requested now.
    assign occ = {1'b0, cnt} + {3'b0, en1} + {3'b0, en2} + {3'b0, cap1} + {3'b0, cap2};

    always_comb begin
        iss1 = 1'b0;
        iss2 = 1'b0;
        if ((launch || (state == ISSUE && rem != '0)) && !abort_hit) begin
            if (rem_src > ONE && occ <= 4'd2)
                iss2 = 1'b1;
            else if (rem_src == ONE && occ <= 4'd3)
                iss1 = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = (bus.len == '0) ? FIN : ISSUE;
            ISSUE:   if (rem == '0) state_nx = DRAIN;
            // Leave as the final word pops so done lands in the cycle right after it.
            DRAIN:   if (cnt == {2'b0, pop} && !en1 && !en2 && !cap1 && !cap2) state_nx = FIN;
            default: state_nx = IDLE;
        endcase
        if (abort_hit) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cur   <= '0;
            rem   <= '0;
            en1   <= 1'b0;
            en2   <= 1'b0;
            cap1  <= 1'b0;
            cap2  <= 1'b0;
            addr1 <= '0;
            addr2 <= '0;
        end else begin
            state <= state_nx;
            cap1  <= en1 && !abort_hit;
            cap2  <= en2 && !abort_hit;
            en1   <= iss1 || iss2;
            en2   <= iss2;
            if (iss2) begin
                addr1 <= cur_src;
                addr2 <= cur_src + A1;
                cur   <= cur_src + A2;
                rem   <= rem_src - TWO;
            end else if (iss1) begin
                addr1 <= cur_src;
                cur   <= cur_src + A1;
                rem   <= rem_src - ONE;
            end else if (launch) begin
                cur   <= cur_src;
                rem   <= rem_src;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (abort_hit) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wp + push_n;
            rp  <= rp + {1'b0, pop};
            cnt <= cnt + {1'b0, push_n} - {2'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (cap1) mem[wp] <= bus.din1;
        if (cap2) mem[wp + {1'b0, cap1}] <= bus.din2;
    end

    assign bus.busy      = (state == ISSUE) || (state == DRAIN);
    assign bus.done      = (state == FIN);
    assign bus.en1       = en1;
    assign bus.en2       = en2;
    assign bus.addr1     = addr1;
    assign bus.addr2     = addr2;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? mem[rp] : '0;
endmodule

// File: tb/tb_dual_port_burst_reader.sv
// Scoreboard bench for dual_port_burst_reader: driver queues expected words, monitor checks the stream.
module tb_dual_port_burst_reader;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dual_port_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
    dual_port_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [15:0] rom [8];
    logic [15:0] exp_q [$];
    int checks = 0, errors = 0, cyc = 0, ready_mode = 0;
    int b_base = 0, b_len = 0, b_issued = 0, b_deliv = 0, b_icyc = 0;
    int start_cyc = 0, last_evt = 0;
    bit done_pend = 0, seen_v = 1, seen_en = 1, hold = 0;
    logic [15:0] hold_data = '0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        done_pend = 0; b_len = 0; b_issued = 0; b_deliv = 0; b_icyc = 0;
        seen_v = 1; seen_en = 1; hold = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_en1"}, int'(bus.en1), 0);
        chk({tag, "_en2"}, int'(bus.en2), 0);
        chk({tag, "_addr1"}, int'(bus.addr1), 0);
        chk({tag, "_addr2"}, int'(bus.addr2), 0);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_out_data"}, int'(bus.out_data), 0);
    endtask

    task automatic start_burst(input int b, input int l);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = 3'(b); bus.len = 4'(l);
        for (int i = 0; i < l; i++) exp_q.push_back(rom[3'(b + i)]);
        b_base = b; b_len = l; b_issued = 0; b_deliv = 0; b_icyc = 0;
        seen_v = 0; seen_en = 0; start_cyc = cyc; last_evt = cyc; done_pend = 1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_pend && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (done_pend) begin
            errors++;
            $display("FAIL done_timeout got pending required done within 300 cycles");
            clear_model();
        end
    endtask

    task automatic wait_delivered(input int k);
        int n = 0;
        while (b_deliv < k && n < 200) begin @(posedge clk); n++; end
        #1;
        chk("wait_delivered", int'(b_deliv >= k), 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ROM model: data appears one edge after the enable is sampled; junk when disabled.
    initial begin
        logic e1, e2;
        logic [2:0] a1, a2;
        bus.din1 = '0; bus.din2 = '0;
        forever begin
            @(posedge clk);
            e1 = bus.en1; e2 = bus.en2; a1 = bus.addr1; a2 = bus.addr2;
            #1;
            bus.din1 = e1 ? rom[a1] : 16'($urandom);
            bus.din2 = e2 ? rom[a2] : 16'($urandom);
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: checks issue pattern against the burst bookkeeping and pops the scoreboard on handshakes.
    initial forever begin
        int n;
        @(negedge clk);
        if (!rst_n) continue;
        n = int'(bus.en1) + int'(bus.en2);
        if (bus.en2) chk("en2_needs_en1", int'(bus.en1), 1);
        if (bus.en1) begin
            if (!seen_en) begin seen_en = 1; chk("en_latency", cyc - start_cyc, 1); end
            chk("issue_in_range", int'(b_issued < b_len), 1);
            chk("addr1", int'(bus.addr1), (b_base + b_issued) & 7);
            chk("en2_pairing", int'(bus.en2), int'((b_len - b_issued) >= 2));
            if (bus.en2) chk("addr2", int'(bus.addr2), (b_base + b_issued + 1) & 7);
            chk("outstanding_le4", int'((b_issued + n - b_deliv) <= 4), 1);
            b_issued += n;
            b_icyc++;
        end
        if (bus.out_valid && !seen_v) begin
            seen_v = 1;
            chk("valid_latency", cyc - start_cyc, 3);
        end
        if (hold) begin
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_data", int'(bus.out_data), int'(hold_data));
        end
        hold = bus.out_valid && !bus.out_ready;
        hold_data = bus.out_data;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_word got %h required no word", bus.out_data);
            end else begin
                chk("data", int'(bus.out_data), int'(exp_q.pop_front()));
            end
            b_deliv++;
            last_evt = cyc;
        end
        if (bus.done) begin
            chk("done_expected", int'(done_pend), 1);
            chk("done_busy_low", int'(bus.busy), 0);
            chk("done_all_words", exp_q.size(), 0);
            chk("done_timing", cyc, last_evt + 1);
            chk("issue_cycles", b_icyc, (b_len + 1) / 2);
            done_pend = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish required finish before 500000");
        $fatal(1);
    end

    initial begin
        rom[0] = 16'habcd; rom[1] = 16'h23cd; rom[2] = 16'h98cd; rom[3] = 16'hcd21;
        rom[4] = 16'h9bc7; rom[5] = 16'h7a3d; rom[6] = 16'h7430; rom[7] = 16'ha525;
        bus.start = 1'b0; bus.base_addr = '0; bus.len = '0;
`ifdef BURST_READER_ABORT_EN
        bus.abort = 1'b0;
`endif
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        start_burst(0, 8); wait_done();
        start_burst(6, 5); wait_done();

        ready_mode = 1;
        start_burst(1, 8);
        repeat (10) @(posedge clk);
        #1;
        chk("stall_issued", b_issued, 4);
        ready_mode = 0;
        wait_done();

        start_burst(5, 0); wait_done();
        start_burst(2, 3);
        chk("busy_during_burst", int'(bus.busy), 1);
        bus.start = 1'b1; bus.base_addr = 3'd5; bus.len = 4'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done();
        repeat (6) @(posedge clk);

        start_burst(2, 8);
        wait_delivered(3);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        clear_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_burst(3, 2); wait_done();

`ifdef BURST_READER_ABORT_EN
        start_burst(0, 8);
        wait_delivered(2);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        clear_model();
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_out_valid", int'(bus.out_valid), 0);
        chk("abort_en1", int'(bus.en1), 0);
        chk("abort_en2", int'(bus.en2), 0);
        repeat (6) @(posedge clk);
        start_burst(4, 1); wait_done();
`endif

        ready_mode = 2;
        for (int i = 0; i < 24; i++) begin
            start_burst(int'($urandom_range(0, 7)), int'($urandom_range(0, 8)));
            wait_done();
        end
        ready_mode = 0;
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
